// File: rtl/dmi_core_req_ctrl.sv
// Core-side DMI request controller: turns a synchronized JTAG register strobe into a
// valid/ready request to the debug module, waits for the response and keeps sticky status.
module dmi_core_req_ctrl #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_en,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [31:0]       reg_wr_data,
    input  logic              dmi_hard_reset,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic              dmi_req_wr,
    output logic [ADDR_W-1:0] dmi_req_addr,
    output logic [31:0]       dmi_req_wdata,
    input  logic              dmi_rsp_valid,
    input  logic              dmi_rsp_err,
    input  logic [31:0]       dmi_rsp_rdata,
    output logic [31:0]       rd_data,
    output logic [1:0]        dmi_stat,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] STAT_OK   = 2'b00;
    localparam logic [1:0] STAT_FAIL = 2'b10;
    localparam logic [1:0] STAT_BUSY = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             busy_hit;
    logic             rsp_fail;
    logic             timed_out;

    // Status events: a strobe while busy, or a failed/expired wait.
    always_comb begin
        busy_hit  = reg_en && (state != IDLE);
        timed_out = (state == WAIT) && !dmi_rsp_valid && (cnt == CNT_LAST);
        rsp_fail  = ((state == WAIT) && dmi_rsp_valid && dmi_rsp_err) || timed_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            busy          <= 1'b0;
            dmi_req_valid <= 1'b0;
            dmi_req_wr    <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_wdata <= '0;
            rd_data       <= '0;
            dmi_stat      <= STAT_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_en) begin
                        dmi_req_wr    <= reg_wr_en;
                        dmi_req_addr  <= reg_wr_addr;
                        dmi_req_wdata <= reg_wr_data;
                        dmi_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    // Valid is never withdrawn here; only a handshake moves on.
                    if (dmi_req_ready) begin
                        dmi_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (dmi_rsp_valid) begin
                        if (!dmi_rsp_err && !dmi_req_wr) begin
                            rd_data <= dmi_rsp_rdata;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timed_out) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    dmi_req_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase

            // Hard reset clear beats any same-cycle event; busy dominates failed.
            if (dmi_hard_reset) begin
                dmi_stat <= STAT_OK;
            end else if (busy_hit) begin
                dmi_stat <= STAT_BUSY;
            end else if (rsp_fail && (dmi_stat != STAT_BUSY)) begin
                dmi_stat <= STAT_FAIL;
            end
        end
    end

endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// Directed bench for dmi_core_req_ctrl: expected requests are queued when the strobe is
// driven and popped at the handshake; response/status expectations come from a small model.
module tb_dmi_core_req_ctrl;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned TIMEOUT = 4;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              reg_en;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [31:0]       reg_wr_data;
    logic              dmi_hard_reset;
    logic              dmi_req_valid;
    logic              dmi_req_ready;
    logic              dmi_req_wr;
    logic [ADDR_W-1:0] dmi_req_addr;
    logic [31:0]       dmi_req_wdata;
    logic              dmi_rsp_valid;
    logic              dmi_rsp_err;
    logic [31:0]       dmi_rsp_rdata;
    logic [31:0]       rd_data;
    logic [1:0]        dmi_stat;
    logic              busy;

    req_t        req_q[$];
    logic [31:0] exp_rd;
    logic [1:0]  exp_stat;
    int          checks = 0;
    int          errors = 0;

    dmi_core_req_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_en        (reg_en),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .dmi_hard_reset(dmi_hard_reset),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_wr    (dmi_req_wr),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_wdata (dmi_req_wdata),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_err   (dmi_rsp_err),
        .dmi_rsp_rdata (dmi_rsp_rdata),
        .rd_data       (rd_data),
        .dmi_stat      (dmi_stat),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; queue the request only if it should be accepted.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                         input bit expect_accept);
        req_t r;
        reg_en      = 1'b1;
        reg_wr_en   = wr;
        reg_wr_addr = addr;
        reg_wr_data = wdata;
        r.wr = wr; r.addr = addr; r.wdata = wdata;
        if (expect_accept) req_q.push_back(r);
        tick();
        reg_en = 1'b0;
    endtask

    // Hold ready low for n cycles, then handshake; valid must stay up with stable fields.
    task automatic accept(input int n);
        req_t e;
        int   hi = 0;
        check("sb_nonempty", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) e = req_q[0];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("valid_held", 32'(dmi_req_valid), 32'd1);
            check("addr_stable", 32'(dmi_req_addr), 32'(e.addr));
            check("wdata_stable", dmi_req_wdata, e.wdata);
            if (dmi_req_valid) hi++;
            tick();
        end
        dmi_req_ready = 1'b1;
        @(negedge clk);
        check("valid_at_hs", 32'(dmi_req_valid), 32'd1);
        if (dmi_req_valid) hi++;
        if (req_q.size() != 0) begin
            e = req_q.pop_front();
            check("req_wr", 32'(dmi_req_wr), 32'(e.wr));
            check("req_addr", 32'(dmi_req_addr), 32'(e.addr));
            check("req_wdata", dmi_req_wdata, e.wdata);
        end
        tick();
        dmi_req_ready = 1'b0;
        check("valid_cycles", 32'(hi), 32'(n + 1));
        @(negedge clk);
        check("valid_dropped", 32'(dmi_req_valid), 32'd0);
        check("busy_in_wait", 32'(busy), 32'd1);
        tick();
    endtask

    task automatic respond(input logic err, input logic [31:0] rdata, input logic hr);
        dmi_rsp_valid  = 1'b1;
        dmi_rsp_err    = err;
        dmi_rsp_rdata  = rdata;
        dmi_hard_reset = hr;
        tick();
        dmi_rsp_valid  = 1'b0;
        dmi_rsp_err    = 1'b0;
        dmi_hard_reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(dmi_req_valid), 32'd0);
        check({tag, "_rd_data"}, rd_data, exp_rd);
        check({tag, "_stat"}, 32'(dmi_stat), 32'(exp_stat));
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(dmi_req_valid), 32'd0);
        check({tag, "_wr"}, 32'(dmi_req_wr), 32'd0);
        check({tag, "_addr"}, 32'(dmi_req_addr), 32'd0);
        check({tag, "_wdata"}, dmi_req_wdata, 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'd0);
        check({tag, "_stat"}, 32'(dmi_stat), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; reg_en = 1'b0; reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0;
        dmi_hard_reset = 1'b0; dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0;
        dmi_rsp_err = 1'b0; dmi_rsp_rdata = '0;
        exp_rd = '0; exp_stat = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Read, ready at once, response in the second wait cycle.
        issue(1'b0, 7'h11, 32'h0, 1'b1);
        accept(0);
        respond(1'b0, 32'hDEADBEEF, 1'b0);
        exp_rd = 32'hDEADBEEF;
        check_idle("read");

        // Write with 5 cycles of backpressure; rd_data untouched.
        issue(1'b1, 7'h10, 32'h80000001, 1'b1);
        accept(5);
        respond(1'b0, 32'h55555555, 1'b0);
        check_idle("write");

        // Timeout after exactly TIMEOUT wait cycles, late response discarded.
        issue(1'b0, 7'h22, 32'h0, 1'b1);
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
            dmi_req_ready = (i == 0);
            if (i == 0) begin
                @(negedge clk);
                check("to_valid", 32'(dmi_req_valid), 32'd1);
                void'(req_q.pop_front());
                tick();
                dmi_req_ready = 1'b0;
            end
        end
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(negedge clk);
            check("to_busy", 32'(busy), 32'd1);
            tick();
        end
        exp_stat = 2'b10;
        @(negedge clk);
        check("to_done_busy", 32'(busy), 32'd0);
        check("to_stat", 32'(dmi_stat), 32'd2);
        tick();
        respond(1'b0, 32'h12345678, 1'b0);
        check_idle("late_rsp");

        // Overlap: strobe during WAIT is dropped, first transaction completes.
        issue(1'b0, 7'h05, 32'h0, 1'b1);
        accept(0);
        issue(1'b1, 7'h7F, 32'hFFFF0000, 1'b0);
        exp_stat = 2'b11;
        @(negedge clk);
        check("ovl_stat", 32'(dmi_stat), 32'd3);
        check("ovl_busy", 32'(busy), 32'd1);
        tick();
        respond(1'b0, 32'hCAFEF00D, 1'b0);
        exp_rd = 32'hCAFEF00D;
        check_idle("ovl_done");
        check("ovl_sb_empty", 32'(req_q.size()), 32'd0);

        // Error response keeps busy status.
        issue(1'b0, 7'h01, 32'h0, 1'b1);
        accept(0);
        respond(1'b1, 32'h11111111, 1'b0);
        check_idle("err_sticky");

        // Hard reset coincident with error: clear wins.
        issue(1'b0, 7'h02, 32'h0, 1'b1);
        accept(0);
        respond(1'b1, 32'h22222222, 1'b1);
        exp_stat = 2'b00;
        check_idle("clear");

        // Response and strobe in the same cycle: strobe dropped as busy.
        issue(1'b0, 7'h03, 32'h0, 1'b1);
        accept(0);
        reg_en = 1'b1; reg_wr_en = 1'b1; reg_wr_addr = 7'h44;
        respond(1'b0, 32'hA5A5A5A5, 1'b0);
        reg_en = 1'b0;
        exp_rd = 32'hA5A5A5A5;
        exp_stat = 2'b11;
        check_idle("rsp_and_en");
        @(negedge clk);
        check("rsp_and_en_no_req", 32'(dmi_req_valid), 32'd0);
        tick();

        // Hard reset with strobe in IDLE: accepted; hard reset in WAIT: not aborted.
        dmi_hard_reset = 1'b1;
        issue(1'b0, 7'h06, 32'h0, 1'b1);
        dmi_hard_reset = 1'b0;
        exp_stat = 2'b00;
        accept(0);
        dmi_hard_reset = 1'b1;
        tick();
        dmi_hard_reset = 1'b0;
        @(negedge clk);
        check("hr_wait_busy", 32'(busy), 32'd1);
        check("hr_wait_stat", 32'(dmi_stat), 32'd0);
        tick();
        respond(1'b0, 32'h0BADF00D, 1'b0);
        exp_rd = 32'h0BADF00D;
        check_idle("hr_done");

        // Reset mid-WAIT abandons the transaction; later response ignored.
        issue(1'b1, 7'h33, 32'h12121212, 1'b1);
        accept(0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_rst");
        tick();
        rst_n = 1'b1;
        exp_rd = '0;
        exp_stat = 2'b00;
        respond(1'b0, 32'hFFFFFFFF, 1'b0);
        check_idle("post_rst");
        check("final_sb_empty", 32'(req_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmi_core_req_ctrl.md
DMI_CORE_REQ_CTRL -- requirements
Module: dmi_core_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set the DMI address width.
REQ-002 Parameter TIMEOUT, default 255, range 1-65535, SHALL set the response wait limit in clk cycles.
REQ-003 clk  input  1  core clock; the block SHALL use this single clock.
REQ-004 rst_n  input  1  core reset, asynchronous, active-low.
REQ-005 reg_en  input  1  single-cycle request strobe from the JTAG-to-core synchronizer.
REQ-006 reg_wr_en  input  1  write qualifier, valid with reg_en.
REQ-007 reg_wr_addr  input  ADDR_W  DMI address, quasi-static from TCK domain, stable when reg_en pulses.
REQ-008 reg_wr_data  input  32  DMI write data, stable when reg_en pulses.
REQ-009 dmi_hard_reset  input  1  pulse that clears sticky status.
REQ-010 dmi_req_valid  output  1  request valid to debug module.
REQ-011 dmi_req_ready  input  1  debug module accepts request.
REQ-012 dmi_req_wr  output  1  1 = write, 0 = read.
REQ-013 dmi_req_addr  output  ADDR_W  captured address.
REQ-014 dmi_req_wdata  output  32  captured write data.
REQ-015 dmi_rsp_valid  input  1  response strobe from debug module.
REQ-016 dmi_rsp_err  input  1  response error, valid with dmi_rsp_valid.
REQ-017 dmi_rsp_rdata  input  32  read data, valid with dmi_rsp_valid.
REQ-018 rd_data  output  32  last successful read data, held for JTAG capture.
REQ-019 dmi_stat  output  2  sticky status: 00 ok, 10 failed, 11 busy.
REQ-020 busy  output  1  transaction in progress.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT; busy SHALL equal (state != IDLE).
REQ-022 IDLE, reg_en=1: capture reg_wr_addr, reg_wr_data, reg_wr_en into dmi_req_* registers, go REQ; dmi_req_valid high the next cycle (1-cycle latency).
REQ-023 REQ: dmi_req_valid SHALL stay high with addr/wdata/wr stable until dmi_req_ready=1; on that cycle go WAIT, dmi_req_valid low the next cycle.
REQ-024 REQ has no timeout; valid SHALL never be withdrawn before ready.
REQ-025 WAIT: timeout counter SHALL start at 0 on entry and increment each cycle without dmi_rsp_valid.
REQ-026 WAIT, dmi_rsp_valid=1, dmi_rsp_err=0: go IDLE; on read, rd_data <= dmi_rsp_rdata; on write, rd_data unchanged.
REQ-027 WAIT, dmi_rsp_valid=1, dmi_rsp_err=1: go IDLE, rd_data unchanged, dmi_stat <= 10 unless already 11.
REQ-028 WAIT, counter reaches TIMEOUT with no response: go IDLE, dmi_stat <= 10 unless already 11.
REQ-029 dmi_rsp_valid SHALL be ignored in IDLE and REQ (late responses after timeout discarded).
REQ-030 reg_en while busy=1 SHALL be dropped, dmi_stat <= 11, outstanding transaction unaffected.
REQ-031 dmi_stat SHALL be sticky: 11 dominates 10; only dmi_hard_reset or rst_n clears to 00.
REQ-032 dmi_hard_reset SHALL NOT abort an outstanding transaction.
REQ-033 dmi_hard_reset and a status-setting event in the same cycle: clear SHALL win, dmi_stat = 00.
REQ-034 dmi_hard_reset and reg_en in IDLE same cycle: request SHALL be accepted normally.
REQ-035 Response completing and reg_en in same cycle: reg_en SHALL be treated as busy (dropped, stat 11).
REQ-036 Timeout counter width SHALL be clog2(TIMEOUT+1); no wrap before TIMEOUT.

Reset
REQ-037 rst_n low SHALL asynchronously force state IDLE, dmi_req_valid 0, dmi_req_wr 0, dmi_req_addr 0, dmi_req_wdata 0, rd_data 0, dmi_stat 00, busy 0, counter 0.
REQ-038 rst_n asserted mid-transaction SHALL abandon it; responses after release SHALL be ignored per REQ-029.

Verification
REQ-039 Read: reg_en, wr_en=0, addr 0x11; ready at once; rsp 2 cycles later rdata 0xDEADBEEF -> valid 1 cycle after reg_en, rd_data=0xDEADBEEF, stat 00, busy low.
REQ-040 Write with backpressure: addr 0x10, wdata 0x80000001, ready low 5 cycles -> valid held 6 cycles, addr/wdata stable, rd_data unchanged.
REQ-041 Timeout: TIMEOUT=4, no rsp -> IDLE after 4 WAIT cycles, stat 10; later rsp ignored, rd_data unchanged.
REQ-042 Overlap: second reg_en during WAIT -> dropped, stat 11, first transaction completes; subsequent rsp_err keeps stat 11.
REQ-043 Clear: dmi_hard_reset coincident with rsp_err -> stat 00.
REQ-044 Reset mid-WAIT: rst_n low 1 cycle -> all outputs reset values; post-reset rsp ignored.
